// File: rtl/cpu_pkg.sv
// Shared definitions for the mox125 operand-fetch stage: register index geometry,
// well-known register numbers and the writeback-bypass capture record.
package cpu_pkg;

  localparam int REG_IDX_W = 4;
  localparam int NREGS     = 16;

  localparam logic [REG_IDX_W-1:0] REG_FP = 4'd0;
  localparam logic [REG_IDX_W-1:0] REG_SP = 4'd1;

  typedef struct packed {
    logic        hit;
    logic [31:0] data;
  } byp_t;

  // Port 1 wins over port 0 when both write the looked-up register.
  function automatic byp_t byp_lookup(
    input logic [REG_IDX_W-1:0] idx,
    input logic                 we0,
    input logic [REG_IDX_W-1:0] idx0,
    input logic [31:0]          d0,
    input logic                 we1,
    input logic [REG_IDX_W-1:0] idx1,
    input logic [31:0]          d1
  );
    byp_t r;
    r.hit  = 1'b0;
    r.data = '0;
    if (we1 && idx1 == idx) begin
      r.hit  = 1'b1;
      r.data = d1;
    end else if (we0 && idx0 == idx) begin
      r.hit  = 1'b1;
      r.data = d0;
    end
    return r;
  endfunction

endpackage

// File: rtl/cpu_operand_fetch_if.sv
// Decode-to-operand-fetch handshake bundle; decode is the master.
interface cpu_operand_fetch_if #(
  parameter int PAYLOAD_W = 32
);
  import cpu_pkg::*;

  logic                 valid;
  logic                 ready;
  logic [REG_IDX_W-1:0] ra_idx;
  logic [REG_IDX_W-1:0] rb_idx;
  logic                 ra_use;
  logic                 rb_use;
  logic                 dest_we;
  logic [REG_IDX_W-1:0] dest_idx;
  logic [PAYLOAD_W-1:0] payload;

  modport master (
    output valid, ra_idx, rb_idx, ra_use, rb_use, dest_we, dest_idx, payload,
    input  ready
  );

  modport slave (
    input  valid, ra_idx, rb_idx, ra_use, rb_use, dest_we, dest_idx, payload,
    output ready
  );

endinterface

// File: rtl/cpu_scoreboard.sv
// Pending-writer bit per register: set on accept, cleared by writeback or flush,
// with set taking priority because the new writer is always the younger one.
module cpu_scoreboard
  import cpu_pkg::*;
#(
  parameter int NREGS = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 set_i,
  input  logic [REG_IDX_W-1:0] set_idx_i,
  input  logic                 wb_we0_i,
  input  logic [REG_IDX_W-1:0] wb_idx0_i,
  input  logic                 wb_we1_i,
  input  logic [REG_IDX_W-1:0] wb_idx1_i,
  input  logic                 flush_clr_i,
  input  logic [REG_IDX_W-1:0] flush_idx_i,
  input  logic                 ra_use_i,
  input  logic [REG_IDX_W-1:0] ra_idx_i,
  input  logic                 rb_use_i,
  input  logic [REG_IDX_W-1:0] rb_idx_i,
  output logic                 haz_o
);

  logic [NREGS-1:0] sb_q, sb_d, wb_clr;

  always_comb begin
    wb_clr = '0;
    for (int r = 0; r < NREGS; r++) begin
      wb_clr[r] = (wb_we0_i && wb_idx0_i == REG_IDX_W'(r)) ||
                  (wb_we1_i && wb_idx1_i == REG_IDX_W'(r));
    end
  end

  always_comb begin
    sb_d = sb_q & ~wb_clr;
    if (flush_clr_i) sb_d[flush_idx_i] = 1'b0;
    if (set_i)       sb_d[set_idx_i]   = 1'b1;
  end

  // A bit retiring this very cycle is covered by the bypass capture.
  assign haz_o = (ra_use_i && sb_q[ra_idx_i] && !wb_clr[ra_idx_i]) ||
                 (rb_use_i && sb_q[rb_idx_i] && !wb_clr[rb_idx_i]);

  always_ff @(posedge clk_i) begin
    if (rst_i) sb_q <= '0;
    else       sb_q <= sb_d;
  end

endmodule

// File: rtl/cpu_operand_fetch.sv
// Register-read stage: issues RF read indices, aligns the 1-cycle RF read data,
// bypasses same-cycle writebacks and stalls decode on RAW hazards.
module cpu_operand_fetch
  import cpu_pkg::*;
#(
  parameter int PAYLOAD_W = 32,
  parameter int NREGS     = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  cpu_operand_fetch_if.slave   dec_if,
  output logic [REG_IDX_W-1:0] reg_read_index0_o,
  output logic [REG_IDX_W-1:0] reg_read_index1_o,
  input  logic [31:0]          rf_value0_i,
  input  logic [31:0]          rf_value1_i,
  input  logic                 wb_we0_i,
  input  logic [REG_IDX_W-1:0] wb_idx0_i,
  input  logic [31:0]          wb_data0_i,
  input  logic                 wb_we1_i,
  input  logic [REG_IDX_W-1:0] wb_idx1_i,
  input  logic [31:0]          wb_data1_i,
  input  logic                 flush_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [31:0]          operand_a_o,
  output logic [31:0]          operand_b_o,
  output logic                 dest_we_o,
  output logic [REG_IDX_W-1:0] dest_idx_o,
  output logic [PAYLOAD_W-1:0] payload_o
);

  logic                 valid_q, first_q;
  byp_t                 byp_a_q, byp_b_q, byp_a_d, byp_b_d;
  logic [31:0]          hold_a_q, hold_b_q;
  logic                 dest_we_q;
  logic [REG_IDX_W-1:0] dest_idx_q;
  logic [PAYLOAD_W-1:0] payload_q;
  logic                 haz, ready, accept, retire;
  logic [31:0]          opa, opb;

  cpu_scoreboard #(.NREGS(NREGS)) u_sb (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .set_i       (accept && dec_if.dest_we),
    .set_idx_i   (dec_if.dest_idx),
    .wb_we0_i    (wb_we0_i),
    .wb_idx0_i   (wb_idx0_i),
    .wb_we1_i    (wb_we1_i),
    .wb_idx1_i   (wb_idx1_i),
    .flush_clr_i (flush_i && valid_q && dest_we_q),
    .flush_idx_i (dest_idx_q),
    .ra_use_i    (dec_if.ra_use),
    .ra_idx_i    (dec_if.ra_idx),
    .rb_use_i    (dec_if.rb_use),
    .rb_idx_i    (dec_if.rb_idx),
    .haz_o       (haz)
  );

  assign reg_read_index0_o = dec_if.ra_idx;
  assign reg_read_index1_o = dec_if.rb_idx;

  assign ready       = !haz && (!valid_q || ready_i) && !flush_i;
  assign dec_if.ready = ready;
  assign accept      = dec_if.valid && ready;
  assign retire      = valid_q && ready_i;

  assign byp_a_d = byp_lookup(dec_if.ra_idx, wb_we0_i, wb_idx0_i, wb_data0_i,
                              wb_we1_i, wb_idx1_i, wb_data1_i);
  assign byp_b_d = byp_lookup(dec_if.rb_idx, wb_we0_i, wb_idx0_i, wb_data0_i,
                              wb_we1_i, wb_idx1_i, wb_data1_i);

  // RF data is only live on the first cycle after accept; afterwards replay the hold copy.
  assign opa = first_q ? (byp_a_q.hit ? byp_a_q.data : rf_value0_i) : hold_a_q;
  assign opb = first_q ? (byp_b_q.hit ? byp_b_q.data : rf_value1_i) : hold_b_q;

  assign valid_o     = valid_q;
  assign operand_a_o = opa;
  assign operand_b_o = opb;
  assign dest_we_o   = dest_we_q;
  assign dest_idx_o  = dest_idx_q;
  assign payload_o   = payload_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q    <= 1'b0;
      first_q    <= 1'b0;
      byp_a_q    <= '0;
      byp_b_q    <= '0;
      hold_a_q   <= '0;
      hold_b_q   <= '0;
      dest_we_q  <= 1'b0;
      dest_idx_q <= '0;
      payload_q  <= '0;
    end else begin
      if (first_q) begin
        hold_a_q <= opa;
        hold_b_q <= opb;
      end
      if (flush_i) begin
        valid_q <= 1'b0;
        first_q <= 1'b0;
      end else if (accept) begin
        valid_q    <= 1'b1;
        first_q    <= 1'b1;
        byp_a_q    <= byp_a_d;
        byp_b_q    <= byp_b_d;
        dest_we_q  <= dec_if.dest_we;
        dest_idx_q <= dec_if.dest_idx;
        payload_q  <= dec_if.payload;
      end else begin
        first_q <= 1'b0;
        if (retire) valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cpu_operand_fetch.sv
// Self-checking bench: the bench plays register file and execute stage, and keeps an
// architectural model (register values, pending writers, stage contents) to predict outputs.
module tb_cpu_operand_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  rd0, rd1;
  logic [31:0] rf_value0_i, rf_value1_i;
  logic        wb_we0, wb_we1;
  logic [3:0]  wb_idx0, wb_idx1;
  logic [31:0] wb_data0, wb_data1;
  logic        flush, valid_o, ready_i, dest_we_o;
  logic [31:0] operand_a_o, operand_b_o, payload_o;
  logic [3:0]  dest_idx_o;

  always #5 clk = ~clk;

  cpu_operand_fetch_if #(.PAYLOAD_W(32)) dec_if();

  cpu_operand_fetch #(.PAYLOAD_W(32), .NREGS(16)) dut (
    .clk_i(clk), .rst_i(rst), .dec_if(dec_if),
    .reg_read_index0_o(rd0), .reg_read_index1_o(rd1),
    .rf_value0_i(rf_value0_i), .rf_value1_i(rf_value1_i),
    .wb_we0_i(wb_we0), .wb_idx0_i(wb_idx0), .wb_data0_i(wb_data0),
    .wb_we1_i(wb_we1), .wb_idx1_i(wb_idx1), .wb_data1_i(wb_data1),
    .flush_i(flush), .valid_o(valid_o), .ready_i(ready_i),
    .operand_a_o(operand_a_o), .operand_b_o(operand_b_o),
    .dest_we_o(dest_we_o), .dest_idx_o(dest_idx_o), .payload_o(payload_o)
  );

  // Architectural model
  logic [31:0] regs [16];
  logic [15:0] pend;
  int          exq[$];
  logic        m_valid, m_ua, m_ub, m_dwe;
  logic [31:0] m_a, m_b, m_pl;
  logic [3:0]  m_didx;
  logic [31:0] rf_n0, rf_n1;
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_outputs();
    chk("valid_o", 32'(valid_o), 32'(m_valid));
    chk("scoreboard", 32'(dut.u_sb.sb_q), 32'(pend));
    if (m_valid) begin
      if (m_ua) chk("operand_a", operand_a_o, m_a);
      if (m_ub) chk("operand_b", operand_b_o, m_b);
      chk("dest_we", 32'(dest_we_o), 32'(m_dwe));
      chk("dest_idx", 32'(dest_idx_o), 32'(m_didx));
      chk("payload", payload_o, m_pl);
    end
  endtask

  task automatic idle_inputs();
    dec_if.valid = 1'b0; dec_if.ra_idx = '0; dec_if.rb_idx = '0;
    dec_if.ra_use = 1'b0; dec_if.rb_use = 1'b0; dec_if.dest_we = 1'b0;
    dec_if.dest_idx = '0; dec_if.payload = '0;
    wb_we0 = 1'b0; wb_idx0 = '0; wb_data0 = '0;
    wb_we1 = 1'b0; wb_idx1 = '0; wb_data1 = '0;
    flush = 1'b0; ready_i = 1'b1;
  endtask

  task automatic wb_remove(input logic [3:0] idx);
    for (int i = 0; i < exq.size(); i++)
      if (exq[i] == int'(idx)) begin exq.delete(i); break; end
  endtask

  // Called at a negedge with inputs already driven; advances one clock.
  task automatic step();
    logic [15:0] clr;
    logic haz, e_rdy, acc, leave;
    #1;
    clr = '0;
    if (wb_we0) clr[wb_idx0] = 1'b1;
    if (wb_we1) clr[wb_idx1] = 1'b1;
    haz = (dec_if.ra_use && pend[dec_if.ra_idx] && !clr[dec_if.ra_idx]) ||
          (dec_if.rb_use && pend[dec_if.rb_idx] && !clr[dec_if.rb_idx]);
    e_rdy = !haz && (!m_valid || ready_i) && !flush;
    chk("ready_o", 32'(dec_if.ready), 32'(e_rdy));
    chk("rd_index0", 32'(rd0), 32'(dec_if.ra_idx));
    chk("rd_index1", 32'(rd1), 32'(dec_if.rb_idx));
    acc   = dec_if.valid && e_rdy;
    leave = m_valid && ready_i && !flush;
    rf_n0 = regs[dec_if.ra_idx];
    rf_n1 = regs[dec_if.rb_idx];
    if (wb_we0) begin regs[wb_idx0] = wb_data0; wb_remove(wb_idx0); end
    if (wb_we1) begin regs[wb_idx1] = wb_data1; wb_remove(wb_idx1); end
    pend = pend & ~clr;
    if (flush && m_valid && m_dwe) pend[m_didx] = 1'b0;
    if (leave && m_dwe) exq.push_back(int'(m_didx));
    if (acc && dec_if.dest_we) pend[dec_if.dest_idx] = 1'b1;
    if (flush) m_valid = 1'b0;
    else if (acc) begin
      m_valid = 1'b1;
      m_a = regs[dec_if.ra_idx]; m_b = regs[dec_if.rb_idx];
      m_ua = dec_if.ra_use; m_ub = dec_if.rb_use;
      m_dwe = dec_if.dest_we; m_didx = dec_if.dest_idx; m_pl = dec_if.payload;
    end else if (leave) m_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rf_value0_i = rf_n0;
    rf_value1_i = rf_n1;
    #1;
    check_outputs();
    idle_inputs();
  endtask

  task automatic accept_ra(input logic [3:0] ra, input logic dwe, input logic [3:0] d,
                           input logic [31:0] pl);
    dec_if.valid = 1'b1; dec_if.ra_idx = ra; dec_if.ra_use = 1'b1;
    dec_if.dest_we = dwe; dec_if.dest_idx = d; dec_if.payload = pl;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) regs[i] = '0;
    pend = '0; m_valid = 1'b0; m_ua = 1'b0; m_ub = 1'b0; m_dwe = 1'b0;
    m_a = '0; m_b = '0; m_pl = '0; m_didx = '0;
    rf_value0_i = '0; rf_value1_i = '0;
    idle_inputs();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(valid_o), 32'h0);
    chk("rst_opa", operand_a_o, 32'h0);
    chk("rst_opb", operand_b_o, 32'h0);
    chk("rst_payload", payload_o, 32'h0);
    chk("rst_dest_we", 32'(dest_we_o), 32'h0);
    chk("rst_dest_idx", 32'(dest_idx_o), 32'h0);
    chk("rst_sb", 32'(dut.u_sb.sb_q), 32'h0);
    rst = 1'b0;

    // Plain read after an earlier writeback
    wb_we0 = 1'b1; wb_idx0 = 4'd2; wb_data0 = 32'h11;
    step();
    accept_ra(4'd2, 1'b0, 4'd0, 32'h1);
    step();
    chk("t1_valid", 32'(valid_o), 32'h1);
    chk("t1_opa", operand_a_o, 32'h11);
    chk("t1_sb", 32'(dut.u_sb.sb_q), 32'h0);

    // Preload the remaining registers with 0x100*(i+1)
    for (int i = 0; i < 8; i++) begin
      if (i != 2) begin wb_we0 = 1'b1; wb_idx0 = 4'(i); wb_data0 = 32'h100 * 32'(i + 1); end
      wb_we1 = 1'b1; wb_idx1 = 4'(i + 8); wb_data1 = 32'h100 * 32'(i + 9);
      step();
    end

    // RAW stall resolved by a same-cycle writeback on port 1
    accept_ra(4'd0, 1'b1, 4'd5, 32'hA);
    step();
    accept_ra(4'd5, 1'b0, 4'd0, 32'hB);
    #1 chk("t2_stall0", 32'(dec_if.ready), 32'h0);
    step();
    accept_ra(4'd5, 1'b0, 4'd0, 32'hB);
    #1 chk("t2_stall1", 32'(dec_if.ready), 32'h0);
    step();
    accept_ra(4'd5, 1'b0, 4'd0, 32'hB);
    wb_we1 = 1'b1; wb_idx1 = 4'd5; wb_data1 = 32'hCAFE;
    #1 chk("t2_release", 32'(dec_if.ready), 32'h1);
    step();
    chk("t2_opa", operand_a_o, 32'hCAFE);
    chk("t2_payload", payload_o, 32'hB);

    // Both writeback ports hit the read register: port 1 wins
    accept_ra(4'd4, 1'b0, 4'd0, 32'hC);
    wb_we0 = 1'b1; wb_idx0 = 4'd4; wb_data0 = 32'h1;
    wb_we1 = 1'b1; wb_idx1 = 4'd4; wb_data1 = 32'h2;
    step();
    chk("t3_opa", operand_a_o, 32'h2);

    // Execute stalls three cycles while the RF output keeps changing
    accept_ra(4'd3, 1'b0, 4'd0, 32'hA5A5);
    step();
    for (int i = 0; i < 3; i++) begin
      ready_i = 1'b0; dec_if.ra_idx = 4'(8 + i);
      step();
      chk("t4_hold_opa", operand_a_o, 32'h400);
      chk("t4_hold_pl", payload_o, 32'hA5A5);
    end
    accept_ra(4'd6, 1'b0, 4'd0, 32'h5A5A);
    step();
    chk("t4_nobubble_valid", 32'(valid_o), 32'h1);
    chk("t4_nobubble_pl", payload_o, 32'h5A5A);
    chk("t4_nobubble_opa", operand_a_o, 32'h700);
    step();

    // Flush of a held writer releases its scoreboard bit
    accept_ra(4'd0, 1'b1, 4'd7, 32'hF0);
    step();
    dec_if.valid = 1'b1; ready_i = 1'b0; flush = 1'b1;
    #1 chk("t5_ready_flush", 32'(dec_if.ready), 32'h0);
    step();
    chk("t5_valid", 32'(valid_o), 32'h0);
    chk("t5_sb7", 32'(dut.u_sb.sb_q[7]), 32'h0);

    // Writeback of r7 in the same cycle a younger r7 writer is accepted
    accept_ra(4'd0, 1'b1, 4'd7, 32'hE1);
    step();
    step();
    accept_ra(4'd7, 1'b1, 4'd7, 32'hE2);
    wb_we1 = 1'b1; wb_idx1 = 4'd7; wb_data1 = 32'h77;
    step();
    chk("t6_sb7", 32'(dut.u_sb.sb_q[7]), 32'h1);
    chk("t6_opa", operand_a_o, 32'h77);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      logic [15:0] clr;
      int p;
      dec_if.valid   = ($urandom_range(0, 9) < 7);
      dec_if.ra_idx  = 4'($urandom_range(0, 15));
      dec_if.rb_idx  = 4'($urandom_range(0, 15));
      dec_if.ra_use  = 1'($urandom_range(0, 1));
      dec_if.rb_use  = 1'($urandom_range(0, 1));
      dec_if.payload = $urandom;
      ready_i = ($urandom_range(0, 3) != 0);
      flush   = ($urandom_range(0, 19) == 0);
      if (exq.size() > 0 && $urandom_range(0, 1) == 1) begin
        p = int'($urandom_range(0, 1));
        if (p == 0) begin wb_we0 = 1'b1; wb_idx0 = 4'(exq[0]); wb_data0 = $urandom; end
        else        begin wb_we1 = 1'b1; wb_idx1 = 4'(exq[0]); wb_data1 = $urandom; end
        if (exq.size() > 1 && $urandom_range(0, 3) == 0) begin
          if (p == 0) begin wb_we1 = 1'b1; wb_idx1 = 4'(exq[1]); wb_data1 = $urandom; end
          else        begin wb_we0 = 1'b1; wb_idx0 = 4'(exq[1]); wb_data0 = $urandom; end
        end
      end
      clr = '0;
      if (wb_we0) clr[wb_idx0] = 1'b1;
      if (wb_we1) clr[wb_idx1] = 1'b1;
      dec_if.dest_idx = 4'($urandom_range(0, 15));
      dec_if.dest_we  = 1'($urandom_range(0, 1)) &&
                        !(pend[dec_if.dest_idx] && !clr[dec_if.dest_idx]);
      step();
    end

    // Drain execute and confirm every pending writer retired
    for (int c = 0; c < 60; c++) begin
      if (exq.size() > 0) begin wb_we0 = 1'b1; wb_idx0 = 4'(exq[0]); wb_data0 = $urandom; end
      step();
    end
    chk("drain_sb", 32'(dut.u_sb.sb_q), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
